// File: rtl/multi_alarm_clock_pkg.sv
// Shared types, constants and time helpers for the multi-alarm clock.
// Times are minute-of-day values, 0..MIN_PER_DAY-1.
package multi_alarm_clock_pkg;

   localparam int MIN_PER_DAY = 1440;
   localparam int TIME_W      = 11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RING,
      ST_SNOOZE
   } ring_state_e;

   // gfedcba, active-high
   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   function automatic logic [4:0] hour_of(input logic [TIME_W-1:0] t);
      logic [TIME_W-1:0] q;
      q = t / TIME_W'(60);
      return q[4:0];
   endfunction

   function automatic logic [5:0] min_of(input logic [TIME_W-1:0] t);
      logic [TIME_W-1:0] r;
      r = t % TIME_W'(60);
      return r[5:0];
   endfunction

   function automatic logic [TIME_W-1:0] mk_time(input logic [4:0] h, input logic [5:0] m);
      return TIME_W'(h) * TIME_W'(60) + TIME_W'(m);
   endfunction

   // Button edits wrap within their own field; a minute edit never carries.
   function automatic logic [TIME_W-1:0] adv_hour(input logic [TIME_W-1:0] t);
      logic [4:0] h;
      h = hour_of(t);
      return mk_time((h == 5'd23) ? 5'd0 : h + 5'd1, min_of(t));
   endfunction

   function automatic logic [TIME_W-1:0] adv_min(input logic [TIME_W-1:0] t);
      logic [5:0] m;
      m = min_of(t);
      return mk_time(hour_of(t), (m == 6'd59) ? 6'd0 : m + 6'd1);
   endfunction

   function automatic logic [3:0] tens_of(input logic [5:0] v);
      logic [5:0] q;
      q = v / 6'd10;
      return q[3:0];
   endfunction

   function automatic logic [3:0] units_of(input logic [5:0] v);
      logic [5:0] r;
      r = v % 6'd10;
      return r[3:0];
   endfunction

endpackage

// File: rtl/multi_alarm_clock_seg7_decode.sv
// One seven-segment digit: BCD digit in, gfedcba segments out, optional blank.
module seg7_decode
   import multi_alarm_clock_pkg::*;
(
   input  logic [3:0] digit_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i) begin
         case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/multi_alarm_clock.sv
// Minute-resolution clock with N alarm slots, snooze and ring timeout.
// Display is 12/24 h seven-segment, showing either current time or a selected slot.
module multi_alarm_clock
   import multi_alarm_clock_pkg::*;
#(
   parameter  int N_ALARMS      = 2,
   parameter  int TICKS_PER_MIN = 60,
   parameter  int SNOOZE_MIN    = 5,
   parameter  int RING_MIN      = 10,
   localparam int SEL_W         = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
   input  logic             CLOCK,
   input  logic             resetn,
   input  logic             set_time,
   input  logic             alarm,
   input  logic             hours,
   input  logic             minutes,
   input  logic             toggle,
   input  logic             snooze,
   input  logic [SEL_W-1:0] alarm_sel,
   input  logic             mode_24h,
   output logic [13:0]      hr_wire,
   output logic [13:0]      min_wire,
   output logic             am_pm_wire,
   output logic             SPEAKER
);

   localparam int PRE_W   = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
   localparam int CNT_MAX = (RING_MIN > SNOOZE_MIN) ? RING_MIN : SNOOZE_MIN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic [TIME_W-1:0]                time_q, time_d, time_inc;
   logic [N_ALARMS-1:0][TIME_W-1:0]  slot_q, slot_d;
   logic [PRE_W-1:0]                 presc_q, presc_d;
   logic [1:0]                       hrs_q, mins_q, snz_q;
   ring_state_e                      state_q, state_d;
   logic [CNT_W-1:0]                 ring_cnt_q, ring_cnt_d;
   logic [CNT_W-1:0]                 snz_cnt_q, snz_cnt_d;

   logic hrs_edge, mins_edge, snz_edge, tick, sel_ok, alarm_hit;

   assign hrs_edge  = hrs_q[0]  & ~hrs_q[1];
   assign mins_edge = mins_q[0] & ~mins_q[1];
   assign snz_edge  = snz_q[0]  & ~snz_q[1];
   assign sel_ok    = int'(alarm_sel) < N_ALARMS;
   assign tick      = !set_time && (presc_q == PRE_W'(TICKS_PER_MIN - 1));
   assign time_inc  = (time_q == TIME_W'(MIN_PER_DAY - 1)) ? '0 : time_q + TIME_W'(1);

   // Only the free-running tick compares against the slots, so edits never ring.
   always_comb begin
      alarm_hit = 1'b0;
      for (int i = 0; i < N_ALARMS; i++)
         if (slot_q[i] == time_inc) alarm_hit = 1'b1;
   end

   always_comb begin
      time_d  = time_q;
      slot_d  = slot_q;
      presc_d = (set_time || tick) ? '0 : presc_q + PRE_W'(1);
      if (set_time) begin
         if (hrs_edge)  time_d = adv_hour(time_d);
         if (mins_edge) time_d = adv_min(time_d);
      end else begin
         if (tick) time_d = time_inc;
         if (alarm && sel_ok) begin
            if (hrs_edge)  slot_d[alarm_sel] = adv_hour(slot_d[alarm_sel]);
            if (mins_edge) slot_d[alarm_sel] = adv_min(slot_d[alarm_sel]);
         end
      end
   end

   always_ff @(posedge CLOCK or negedge resetn) begin
      if (!resetn) begin
         time_q  <= '0;
         slot_q  <= '0;
         presc_q <= '0;
         hrs_q   <= '0;
         mins_q  <= '0;
         snz_q   <= '0;
      end else begin
         time_q  <= time_d;
         slot_q  <= slot_d;
         presc_q <= presc_d;
         hrs_q   <= {hrs_q[0], hours};
         mins_q  <= {mins_q[0], minutes};
         snz_q   <= {snz_q[0], snooze};
      end
   end

   always_ff @(posedge CLOCK or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         ring_cnt_q <= '0;
         snz_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         ring_cnt_q <= ring_cnt_d;
         snz_cnt_q  <= snz_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
      snz_cnt_d  = snz_cnt_q;
      if (!toggle) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (tick && alarm_hit) begin
               state_d    = ST_RING;
               ring_cnt_d = '0;
            end
            ST_RING: begin
               if (snz_edge) begin
                  state_d   = ST_SNOOZE;
                  snz_cnt_d = CNT_W'(SNOOZE_MIN);
               end else if (tick) begin
                  if (ring_cnt_q >= CNT_W'(RING_MIN - 1)) state_d = ST_IDLE;
                  else ring_cnt_d = ring_cnt_q + CNT_W'(1);
               end
            end
            ST_SNOOZE: if (tick) begin
               if (snz_cnt_q <= CNT_W'(1)) begin
                  state_d    = ST_RING;
                  ring_cnt_d = '0;
               end else begin
                  snz_cnt_d = snz_cnt_q - CNT_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   logic [TIME_W-1:0] src;
   logic [4:0]        hr24, disp_hr;
   logic [5:0]        mn;
   logic [3:0]        hr_t, hr_u, mn_t, mn_u;

   assign src = (alarm && !set_time && sel_ok) ? slot_q[alarm_sel] : time_q;
   assign hr24 = hour_of(src);
   assign mn   = min_of(src);

   always_comb begin
      disp_hr = hr24;
      if (!mode_24h) begin
         if (hr24 == 5'd0)       disp_hr = 5'd12;
         else if (hr24 > 5'd12)  disp_hr = hr24 - 5'd12;
      end
   end

   assign hr_t = tens_of({1'b0, disp_hr});
   assign hr_u = units_of({1'b0, disp_hr});
   assign mn_t = tens_of(mn);
   assign mn_u = units_of(mn);

   seg7_decode u_hr_t (.digit_i(hr_t), .blank_i(!mode_24h && hr_t == 4'd0), .seg_o(hr_wire[13:7]));
   seg7_decode u_hr_u (.digit_i(hr_u), .blank_i(1'b0), .seg_o(hr_wire[6:0]));
   seg7_decode u_mn_t (.digit_i(mn_t), .blank_i(1'b0), .seg_o(min_wire[13:7]));
   seg7_decode u_mn_u (.digit_i(mn_u), .blank_i(1'b0), .seg_o(min_wire[6:0]));

   assign am_pm_wire = !mode_24h && (hr24 >= 5'd12);
   assign SPEAKER    = (state_q == ST_RING);

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock with a 4-cycle minute, 2-minute snooze
// and 3-minute ring timeout.
module tb_multi_alarm_clock;

   localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F;
   localparam logic [6:0] S5 = 7'h6D, S9 = 7'h6F, SB = 7'h00;

   logic        CLOCK = 1'b0;
   logic        resetn, set_time, alarm, hours, minutes, toggle, snooze, mode_24h;
   logic [0:0]  alarm_sel;
   logic [13:0] hr_wire, min_wire;
   logic        am_pm_wire, SPEAKER;

   int n_tests = 0;
   int n_fail  = 0;

   multi_alarm_clock #(
      .N_ALARMS(2), .TICKS_PER_MIN(4), .SNOOZE_MIN(2), .RING_MIN(3)
   ) dut (
      .CLOCK(CLOCK), .resetn(resetn), .set_time(set_time), .alarm(alarm),
      .hours(hours), .minutes(minutes), .toggle(toggle), .snooze(snooze),
      .alarm_sel(alarm_sel), .mode_24h(mode_24h), .hr_wire(hr_wire),
      .min_wire(min_wire), .am_pm_wire(am_pm_wire), .SPEAKER(SPEAKER)
   );

   always #5 CLOCK = ~CLOCK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1);
   end

   task automatic press_h();
      hours = 1'b1;
      repeat (2) @(negedge CLOCK);
      hours = 1'b0;
      repeat (2) @(negedge CLOCK);
   endtask

   task automatic press_m();
      minutes = 1'b1;
      repeat (2) @(negedge CLOCK);
      minutes = 1'b0;
      repeat (2) @(negedge CLOCK);
   endtask

   // Leaves the bench at the negedge where resetn rises.
   task automatic do_reset(input logic st, input logic al, input logic sel);
      @(negedge CLOCK);
      resetn = 1'b0;
      set_time = st; alarm = al; alarm_sel = sel;
      hours = 0; minutes = 0; snooze = 0; toggle = 0;
      repeat (2) @(negedge CLOCK);
      resetn = 1'b1;
   endtask

   // Slot1 = 00:02, time = 00:00, toggle armed; ends in set_time mode at a negedge.
   task automatic setup_alarm();
      do_reset(1'b0, 1'b1, 1'b1);
      mode_24h = 1'b1;
      press_m();
      press_m();
      alarm_sel = 1'b0;
      #1;
      n_tests++;
      if (min_wire !== {S0, S0}) begin
         n_fail++; $display("FAIL view_slot0: min_wire got %h want %h", min_wire, {S0, S0});
      end
      alarm_sel = 1'b1;
      #1;
      n_tests++;
      if (min_wire !== {S0, S2}) begin
         n_fail++; $display("FAIL view_slot1: min_wire got %h want %h", min_wire, {S0, S2});
      end
      set_time = 1'b1;
      alarm = 1'b0;
      // time ran to 00:02 while the slot was edited; 58 edits wrap minutes to 00
      repeat (58) press_m();
      n_tests++;
      if (hr_wire !== {S0, S0} || min_wire !== {S0, S0}) begin
         n_fail++; $display("FAIL min_wrap: hr %h min %h want %h %h", hr_wire, min_wire, {S0, S0}, {S0, S0});
      end
      toggle = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge CLOCK);
      resetn = 1'b0;
      set_time = 0; alarm = 0; hours = 0; minutes = 0; snooze = 0; toggle = 0;
      alarm_sel = 0; mode_24h = 1'b0;
      #1;
      n_tests++;
      if (hr_wire !== {S1, S2} || min_wire !== {S0, S0} || am_pm_wire !== 1'b0 || SPEAKER !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_12h: hr %h min %h ampm %b spk %b want %h %h 0 0",
                  hr_wire, min_wire, am_pm_wire, SPEAKER, {S1, S2}, {S0, S0});
      end
      mode_24h = 1'b1;
      #1;
      n_tests++;
      if (hr_wire !== {S0, S0} || am_pm_wire !== 1'b0) begin
         n_fail++; $display("FAIL reset_24h: hr %h ampm %b want %h 0", hr_wire, am_pm_wire, {S0, S0});
      end
      @(negedge CLOCK);
      resetn = 1'b1;
   endtask

   task automatic test_hour_12_24();
      do_reset(1'b1, 1'b0, 1'b0);
      repeat (13) press_h();
      mode_24h = 1'b0;
      #1;
      n_tests++;
      if (hr_wire !== {SB, S1} || am_pm_wire !== 1'b1 || min_wire !== {S0, S0}) begin
         n_fail++;
         $display("FAIL hour13_12h: hr %h ampm %b min %h want %h 1 %h", hr_wire, am_pm_wire, min_wire, {SB, S1}, {S0, S0});
      end
      mode_24h = 1'b1;
      #1;
      n_tests++;
      if (hr_wire !== {S1, S3} || am_pm_wire !== 1'b0) begin
         n_fail++; $display("FAIL hour13_24h: hr %h ampm %b want %h 0", hr_wire, am_pm_wire, {S1, S3});
      end
   endtask

   task automatic test_midnight();
      do_reset(1'b1, 1'b0, 1'b0);
      mode_24h = 1'b1;
      repeat (23) press_h();
      repeat (59) press_m();
      n_tests++;
      if (hr_wire !== {S2, S3} || min_wire !== {S5, S9}) begin
         n_fail++; $display("FAIL set_2359: hr %h min %h want %h %h", hr_wire, min_wire, {S2, S3}, {S5, S9});
      end
      set_time = 1'b0;
      repeat (3) @(negedge CLOCK);
      mode_24h = 1'b0;
      #1;
      n_tests++;
      if (hr_wire !== {S1, S1} || am_pm_wire !== 1'b1 || min_wire !== {S5, S9}) begin
         n_fail++;
         $display("FAIL pre_wrap_12h: hr %h ampm %b min %h want %h 1 %h", hr_wire, am_pm_wire, min_wire, {S1, S1}, {S5, S9});
      end
      mode_24h = 1'b1;
      @(negedge CLOCK);
      n_tests++;
      if (hr_wire !== {S0, S0} || min_wire !== {S0, S0}) begin
         n_fail++; $display("FAIL wrap_24h: hr %h min %h want %h %h", hr_wire, min_wire, {S0, S0}, {S0, S0});
      end
      mode_24h = 1'b0;
      #1;
      n_tests++;
      if (hr_wire !== {S1, S2} || am_pm_wire !== 1'b0) begin
         n_fail++; $display("FAIL wrap_12h: hr %h ampm %b want %h 0", hr_wire, am_pm_wire, {S1, S2});
      end
   endtask

   task automatic test_ring_timeout();
      setup_alarm();
      set_time = 1'b0;
      for (int k = 1; k <= 22; k++) begin
         logic exp;
         @(negedge CLOCK);
         exp = (k >= 8 && k < 20);
         n_tests++;
         if (SPEAKER !== exp) begin
            n_fail++; $display("FAIL ring_timeout cyc %0d: SPEAKER got %b want %b", k, SPEAKER, exp);
         end
      end
   endtask

   task automatic test_snooze();
      setup_alarm();
      set_time = 1'b0;
      repeat (8) @(negedge CLOCK);
      n_tests++;
      if (SPEAKER !== 1'b1) begin
         n_fail++; $display("FAIL snooze_ring_start: SPEAKER got %b want 1", SPEAKER);
      end
      snooze = 1'b1;
      @(negedge CLOCK);
      snooze = 1'b0;
      for (int k = 10; k <= 16; k++) begin
         logic exp;
         @(negedge CLOCK);
         exp = (k >= 16);
         n_tests++;
         if (SPEAKER !== exp) begin
            n_fail++; $display("FAIL snooze_period cyc %0d: SPEAKER got %b want %b", k, SPEAKER, exp);
         end
      end
      snooze = 1'b1;
      @(negedge CLOCK);
      snooze = 1'b0;
      @(negedge CLOCK);
      toggle = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge CLOCK);
         n_tests++;
         if (SPEAKER !== 1'b0) begin
            n_fail++; $display("FAIL disarm_in_snooze cyc %0d: SPEAKER got %b want 0", k, SPEAKER);
         end
      end
   endtask

   task automatic test_edit_no_ring();
      setup_alarm();
      press_m();
      press_m();
      n_tests++;
      if (min_wire !== {S0, S2} || SPEAKER !== 1'b0) begin
         n_fail++; $display("FAIL edit_match: min %h spk %b want %h 0", min_wire, SPEAKER, {S0, S2});
      end
      repeat (4) @(negedge CLOCK);
      set_time = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLOCK);
         n_tests++;
         if (SPEAKER !== 1'b0) begin
            n_fail++; $display("FAIL edit_no_ring cyc %0d: SPEAKER got %b want 0", k, SPEAKER);
         end
      end
   endtask

   task automatic test_reset_in_ring();
      setup_alarm();
      set_time = 1'b0;
      repeat (8) @(negedge CLOCK);
      n_tests++;
      if (SPEAKER !== 1'b1) begin
         n_fail++; $display("FAIL rst_ring_start: SPEAKER got %b want 1", SPEAKER);
      end
      mode_24h = 1'b0;
      #2;
      resetn = 1'b0;
      #1;
      n_tests++;
      if (SPEAKER !== 1'b0 || hr_wire !== {S1, S2} || min_wire !== {S0, S0} || am_pm_wire !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_in_ring: spk %b hr %h min %h ampm %b want 0 %h %h 0",
                  SPEAKER, hr_wire, min_wire, am_pm_wire, {S1, S2}, {S0, S0});
      end
      @(negedge CLOCK);
      resetn = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge CLOCK);
         n_tests++;
         if (SPEAKER !== 1'b0) begin
            n_fail++; $display("FAIL rst_residual cyc %0d: SPEAKER got %b want 0", k, SPEAKER);
         end
      end
   endtask

   initial begin
      resetn = 1'b0;
      set_time = 0; alarm = 0; hours = 0; minutes = 0; snooze = 0; toggle = 0;
      alarm_sel = 0; mode_24h = 0;
      test_reset();
      test_hour_12_24();
      test_midnight();
      test_ring_timeout();
      test_snooze();
      test_edit_no_ring();
      test_reset_in_ring();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_alarm_clock.md
MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 Parameters SHALL be: N_ALARMS, default 2, number of alarm slots (1..8); TICKS_PER_MIN, default 60, CLOCK cycles per minute; SNOOZE_MIN, default 5, snooze length in minutes; RING_MIN, default 10, ring timeout in minutes.
REQ-002 Ports SHALL be, in order:
- CLOCK, in, 1: sole clock, rising edge.
- resetn, in, 1: asynchronous active-low reset.
- set_time, in, 1: time-edit mode level.
- alarm, in, 1: alarm-edit/view mode level.
- hours, in, 1: hour-advance button level.
- minutes, in, 1: minute-advance button level.
- toggle, in, 1: alarm arm switch level.
- snooze, in, 1: snooze button level.
- alarm_sel, in, max(1,$clog2(N_ALARMS)): selected alarm slot.
- mode_24h, in, 1: 1 = 24 h display, 0 = 12 h display.
- hr_wire, out, 14: hour digits; [13:7] tens, [6:0] units, gfedcba, active-high.
- min_wire, out, 14: minute digits, same format.
- am_pm_wire, out, 1: 1 = PM.
- SPEAKER, out, 1: alarm sound enable.

Function
REQ-003 Time SHALL be held as minute-of-day, 11 bits, range 0..1439; each alarm slot SHALL use the same format.
REQ-004 A prescaler SHALL count 0..TICKS_PER_MIN-1; a minute tick SHALL occur on wrap, advancing time by 1; 1439 SHALL wrap to 0.
REQ-005 hours, minutes and snooze SHALL be registered; an action SHALL occur once per 0->1 transition, one cycle after the edge is sampled.
REQ-006 While set_time=1: the prescaler SHALL be held at 0; no ticks SHALL occur; a hours edge SHALL advance the hour mod 24; a minutes edge SHALL advance the minute mod 60 with no hour carry.
REQ-007 While alarm=1 and set_time=0, hours/minutes edges SHALL edit slot alarm_sel with the same wrap rules; set_time SHALL take priority.
REQ-008 The display source SHALL be slot alarm_sel when alarm=1 and set_time=0, otherwise current time.
REQ-009 In 12 h mode, hour 0 SHALL display as 12, hours 13..23 as 1..11, am_pm_wire SHALL be (hour>=12), and a zero hour-tens digit SHALL be blanked (7'b0).
REQ-010 In 24 h mode, am_pm_wire SHALL be 0 and the hour-tens digit SHALL show 0; minute tens SHALL never be blanked.
REQ-011 The ring FSM SHALL have states IDLE, RING and SNOOZE; SPEAKER SHALL be 1 only in RING.
REQ-012 IDLE->RING SHALL occur on a minute tick whose new time equals any slot while toggle=1; manual edits SHALL never trigger a match.
REQ-013 RING->SNOOZE SHALL occur on a snooze edge, loading the countdown with SNOOZE_MIN; each tick SHALL decrement it, and reaching 0 SHALL return to RING.
REQ-014 RING->IDLE SHALL occur after RING_MIN ticks in RING without snooze.
REQ-015 toggle=0 SHALL force IDLE from any state, overriding a simultaneous snooze edge; a snooze edge in IDLE SHALL be ignored.
REQ-016 Outputs SHALL be combinational from registered state; edits SHALL show on the display the cycle after the action.

Reset
REQ-017 resetn=0 SHALL clear time, all slots, prescaler, edge registers and snooze and ring counters, and SHALL force IDLE, asynchronously.
REQ-018 Under reset, SPEAKER SHALL be 0 and am_pm_wire 0; the display SHALL show "12:00" (hr tens blank) when mode_24h=0 and "00:00" when mode_24h=1.
REQ-019 Reset asserted mid-RING or mid-SNOOZE SHALL abandon the ring with no residual SPEAKER pulse.

Structure
REQ-020 Package multi_alarm_clock_pkg SHALL hold the FSM state enum, MIN_PER_DAY=1440, TIME_W=11 and the seven-segment digit constants (0-9, blank).
REQ-021 A single sub-module seg7_decode (4-bit digit plus blank in, 7-bit out) SHALL be instantiated four times.

Verification (TICKS_PER_MIN=4, SNOOZE_MIN=2, RING_MIN=3, N_ALARMS=2)
REQ-022 Reset, then set_time=1 with 13 hours edges and mode_24h=0 -> hr shows " 1", am_pm_wire=1; with mode_24h=1 -> "13", am_pm_wire=0.
REQ-023 Time 23:59 free-running -> after 4 cycles "00:00"; in 12 h mode "12:00", am_pm_wire=0.
REQ-024 Slot 1=00:02, toggle=1, time 00:00 -> SPEAKER=1 exactly on the tick producing 00:02, then 0 after 3 more ticks.
REQ-025 While ringing, snooze pulse -> SPEAKER=0 for 2 ticks, then 1; toggle=0 during SNOOZE -> IDLE, SPEAKER stays 0.
REQ-026 Editing time to equal an armed alarm via minutes edges -> no ring; assert resetn=0 during RING -> SPEAKER=0 immediately and display "12:00".
